// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the tagged split-transaction bus.
//
// Accepts BUS_LOAD / BUS_STORE commands, hands out a nonzero tag (1..15) in
// the same cycle, and returns that tag together with the load data exactly
// LATENCY cycles later for a single cycle. Stores write the backing store at
// the acceptance edge and complete with data 0.
//
// Ports:
//   clock              clock
//   reset              synchronous, active-high reset
//   proc2mem_command   0=NONE, 1=LOAD, 2=STORE, 3=NONE
//   proc2mem_addr      byte address, bits [2:0] ignored, upper bits alias
//   proc2mem_data      store data
//   mem2proc_response  combinational accept tag, 0 = refused / no request
//   mem2proc_data      registered load data, valid while mem2proc_tag != 0
//   mem2proc_tag       registered completion tag, nonzero for one cycle
//
// Optional feature: define MEM_BUSY_INJECT_EN to refuse every request that
// arrives in the last cycle of a free-running BUSY_PERIOD counter.
module mem_responder #(
    parameter int LATENCY     = 4,
    parameter int MEM_WORDS   = 1024,
    parameter int BUSY_PERIOD = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [63:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // Lowest-numbered free tag, 0 when the pool is exhausted.
    function automatic logic [3:0] lowest_free(input logic [14:0] busy);
        logic [3:0] tag;
        tag = 4'd0;
        for (int i = 14; i >= 0; i--) begin
            if (!busy[i]) begin
                tag = 4'(i + 1);
            end else begin
                tag = tag;
            end
        end
        return tag;
    endfunction

    // One-hot busy-vector mask for a tag; tag 0 maps to an empty mask.
    function automatic logic [14:0] tag_mask(input logic [3:0] tag);
        logic [14:0] m;
        m = 15'd0;
        for (int i = 0; i < 15; i++) begin
            m[i] = (tag == 4'(i + 1));
        end
        return m;
    endfunction

    logic [63:0]      mem_r [MEM_WORDS];
    logic [14:0]      busy_tags_r;
    // A pipeline stage is valid exactly when its tag is nonzero.
    logic [3:0]       pipe_tag_r  [LATENCY];
    logic [63:0]      pipe_data_r [LATENCY];

    logic [IDX_W-1:0] word_idx_s;
    logic [3:0]       free_tag_s;
    logic             is_load_s;
    logic             is_store_s;
    logic             accept_s;
    logic             busy_cycle_s;
    logic [63:0]      entry_data_s;
    logic             addr_unused_s;

    assign word_idx_s    = proc2mem_addr[3 +: IDX_W];
    assign addr_unused_s = ^{proc2mem_addr[63:IDX_W+3], proc2mem_addr[2:0]};
    assign free_tag_s    = lowest_free(busy_tags_r);

`ifdef MEM_BUSY_INJECT_EN
    localparam int CNT_W = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_PERIOD - 1);

    logic [CNT_W-1:0] busy_cnt_r;

    // Free-running refusal counter, wraps at BUSY_PERIOD-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_cnt_r <= {CNT_W{1'b0}};
        end else if (busy_cnt_r == CNT_MAX) begin
            busy_cnt_r <= {CNT_W{1'b0}};
        end else begin
            busy_cnt_r <= busy_cnt_r + CNT_W'(1);
        end
    end

    assign busy_cycle_s = (busy_cnt_r == CNT_MAX);
`else
    localparam int UNUSED_BUSY_PERIOD = BUSY_PERIOD;
    assign busy_cycle_s = 1'b0;
`endif

    // Command decode; encoding 3 behaves like BUS_NONE.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        case (proc2mem_command)
            2'd1:    is_load_s  = 1'b1;
            2'd2:    is_store_s = 1'b1;
            default: begin
                is_load_s  = 1'b0;
                is_store_s = 1'b0;
            end
        endcase
    end

    // Acceptance decision and same-cycle tag response.
    always_comb begin
        accept_s          = 1'b0;
        mem2proc_response = 4'd0;
        if ((is_load_s || is_store_s) && !reset &&
            (free_tag_s != 4'd0) && !busy_cycle_s) begin
            accept_s          = 1'b1;
            mem2proc_response = free_tag_s;
        end else begin
            accept_s          = 1'b0;
            mem2proc_response = 4'd0;
        end
    end

    // Load data is captured from the array before this edge's store lands.
    always_comb begin
        entry_data_s = 64'd0;
        if (accept_s && is_load_s) begin
            entry_data_s = mem_r[word_idx_s];
        end else begin
            entry_data_s = 64'd0;
        end
    end

    // Backing store; contents survive reset.
    always_ff @(posedge clock) begin
        if (accept_s && is_store_s) begin
            mem_r[word_idx_s] <= proc2mem_data;
        end
    end

    // Tag pool: free the completing tag, claim the newly accepted one.
    // The completing tag is still busy this cycle, so the two never collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_tags_r <= 15'd0;
        end else begin
            busy_tags_r <= (busy_tags_r & ~tag_mask(mem2proc_tag)) |
                           (accept_s ? tag_mask(free_tag_s) : 15'd0);
        end
    end

    // Fixed-latency shift register; the last stage is the output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag_r[i]  <= 4'd0;
                pipe_data_r[i] <= 64'd0;
            end
        end else begin
            pipe_tag_r[0]  <= accept_s ? free_tag_s : 4'd0;
            pipe_data_r[0] <= entry_data_s;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_tag_r[i]  <= pipe_tag_r[i-1];
                pipe_data_r[i] <= pipe_data_r[i-1];
            end
        end
    end

    assign mem2proc_tag  = pipe_tag_r[LATENCY-1];
    assign mem2proc_data = pipe_data_r[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (LATENCY=4, MEM_WORDS=1024,
// BUSY_PERIOD=8). A per-cycle vector table covers store/load round trips,
// back-to-back loads, mid-flight reset, illegal commands and address
// aliasing; a hand-written sequence holds LOAD continuously from reset.
// With MEM_BUSY_INJECT_EN defined, only the continuous-hold sequence runs,
// with the forced refusals in its expected values.
module tb_mem_responder;

    logic        clock;
    logic        reset;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    int total;
    int bad;

    typedef struct {
        logic        rst;
        logic [1:0]  cmd;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  resp;
        logic [3:0]  tag;
        logic [63:0] data;
    } vec_t;

    vec_t vecs[$];

    mem_responder #(
        .LATENCY     (4),
        .MEM_WORDS   (1024),
        .BUSY_PERIOD (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic addv(input logic rst, input logic [1:0] cmd, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [3:0] resp,
                        input logic [3:0] tag, input logic [63:0] data);
        vec_t v;
        v.rst = rst; v.cmd = cmd; v.addr = addr; v.wdata = wdata;
        v.resp = resp; v.tag = tag; v.data = data;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs just after the falling edge.
    task automatic drive(input logic rst, input logic [1:0] cmd,
                         input logic [63:0] addr, input logic [63:0] wdata);
        @(negedge clock);
        reset            = rst;
        proc2mem_command = cmd;
        proc2mem_addr    = addr;
        proc2mem_data    = wdata;
        #1;
    endtask

    // Continuous LOAD of address 0 from reset; tag returns 4 cycles later.
    task automatic hold_sequence(input logic [3:0] exp_resp [16], input int n);
        logic [3:0] exp_tag;
        for (int c = 0; c < n; c++) begin
            drive(1'b0, 2'd1, 64'h0, 64'h0);
            exp_tag = (c >= 4) ? exp_resp[c-4] : 4'd0;
            check($sformatf("hold%0d_resp", c), {60'd0, mem2proc_response}, {60'd0, exp_resp[c]});
            check($sformatf("hold%0d_tag", c), {60'd0, mem2proc_tag}, {60'd0, exp_tag});
            check($sformatf("hold%0d_data", c), mem2proc_data,
                  (exp_tag != 4'd0) ? 64'h1111 : 64'h0);
        end
    endtask

    initial begin
        logic [3:0] hold_exp [16];
        total = 0;
        bad   = 0;
        reset = 1'b1;
        proc2mem_command = 2'd0;
        proc2mem_addr    = 64'h0;
        proc2mem_data    = 64'h0;
        repeat (2) @(posedge clock);

`ifndef MEM_BUSY_INJECT_EN
        // rst cmd addr wdata | resp tag data
        addv(1'b1, 2'd1, 64'h40, 64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd2, 64'h40, 64'hDEADBEEF, 4'd1, 4'd0, 64'h0);
        addv(1'b0, 2'd1, 64'h40, 64'h0,        4'd2, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd1, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd2, 64'hDEADBEEF);
        addv(1'b0, 2'd2, 64'h0,  64'h1111,     4'd1, 4'd0, 64'h0);
        addv(1'b0, 2'd2, 64'h8,  64'h2222,     4'd2, 4'd0, 64'h0);
        addv(1'b0, 2'd2, 64'h10, 64'h3333,     4'd3, 4'd0, 64'h0);
        addv(1'b0, 2'd2, 64'h18, 64'h4444,     4'd4, 4'd0, 64'h0);
        addv(1'b1, 2'd0, 64'h0,  64'h0,        4'd0, 4'd1, 64'h0);
        addv(1'b0, 2'd1, 64'h0,  64'h0,        4'd1, 4'd0, 64'h0);
        addv(1'b0, 2'd1, 64'h8,  64'h0,        4'd2, 4'd0, 64'h0);
        addv(1'b0, 2'd1, 64'h10, 64'h0,        4'd3, 4'd0, 64'h0);
        addv(1'b0, 2'd1, 64'h18, 64'h0,        4'd4, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd1, 64'h1111);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd2, 64'h2222);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd3, 64'h3333);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd4, 64'h4444);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd3, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd3, 64'h8,  64'h7777,     4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd1, 64'h2000, 64'h0,      4'd1, 4'd0, 64'h0);
        addv(1'b0, 2'd2, 64'h2008, 64'h5555,   4'd2, 4'd0, 64'h0);
        addv(1'b0, 2'd1, 64'h8,  64'h0,        4'd3, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd1, 64'h1111);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd2, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd3, 64'h5555);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd1, 64'h10, 64'h0,        4'd1, 4'd0, 64'h0);
        addv(1'b0, 2'd1, 64'h18, 64'h0,        4'd2, 4'd0, 64'h0);
        addv(1'b0, 2'd1, 64'h0,  64'h0,        4'd3, 4'd0, 64'h0);
        addv(1'b1, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd1, 64'h10, 64'h0,        4'd1, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd1, 64'h3333);
        addv(1'b0, 2'd0, 64'h0,  64'h0,        4'd0, 4'd0, 64'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
            check($sformatf("row%0d_resp", i), {60'd0, mem2proc_response}, {60'd0, vecs[i].resp});
            check($sformatf("row%0d_tag", i), {60'd0, mem2proc_tag}, {60'd0, vecs[i].tag});
            check($sformatf("row%0d_data", i), mem2proc_data, vecs[i].data);
        end
`endif

        // Seed word 0, then reset so the hold sequence starts from cycle 0.
        drive(1'b1, 2'd0, 64'h0, 64'h0);
        drive(1'b0, 2'd2, 64'h0, 64'h1111);
        check("seed_resp", {60'd0, mem2proc_response}, 64'd1);
        drive(1'b1, 2'd0, 64'h0, 64'h0);
        drive(1'b1, 2'd0, 64'h0, 64'h0);
        check("reset_tag", {60'd0, mem2proc_tag}, 64'd0);
        check("reset_data", mem2proc_data, 64'd0);

`ifdef MEM_BUSY_INJECT_EN
        hold_exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd0,
                     4'd3, 4'd4, 4'd1, 4'd2, 4'd5, 4'd3, 4'd4, 4'd0};
        hold_sequence(hold_exp, 16);
`else
        hold_exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd3,
                     4'd4, 4'd5, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
        hold_sequence(hold_exp, 12);
`endif

        drive(1'b0, 2'd0, 64'h0, 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
